// File: rtl/perip_bus_initiator_pkg.sv
// Shared types and constants for the system-peripheral register bus initiator.
package perip_bus_initiator_pkg;

  // Initiator FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  // Register offsets are word aligned; any set bit here marks a bad access
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // Timer block register offsets on the peripheral bus
  localparam logic [7:0] TIMER_CTRL = 8'h00;
  localparam logic [7:0] TIMER_CMPO = 8'h04;
  localparam logic [7:0] TIMER_CAPI = 8'h08;
  localparam logic [7:0] TIMER_TCOF = 8'h0C;

  // True when the low address bits make the access unaligned
  function automatic logic is_unaligned(input logic [1:0] lsbs);
    return (lsbs & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/perip_bus_initiator_if.sv
// Core-side request/response handshake plus peripheral bus signals.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1; a response transfers on a rising edge where
// rsp_valid_o and rsp_ready_i are both 1. Once raised, rsp_valid_o and its
// payload stay unchanged until that transfer. The requester keeps its payload
// stable while req_valid_i is high and not yet accepted.
interface perip_bus_initiator_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  // core request
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic [SEL_W-1:0]  req_sel_i;
  // core response
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  // peripheral bus
  logic [ADDR_W-1:0] waddr_o;
  logic [DATA_W-1:0] data_o;
  logic [SEL_W-1:0]  sel_o;
  logic              we_o;
  logic [ADDR_W-1:0] raddr_o;
  logic              rd_o;
  logic [DATA_W-1:0] data_i;

  // The initiator itself
  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
    input  rsp_ready_i, data_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output waddr_o, data_o, sel_o, we_o, raddr_o, rd_o
  );

  // Everything around it: core plus peripheral slaves
  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
    output rsp_ready_i, data_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  waddr_o, data_o, sel_o, we_o, raddr_o, rd_o
  );

endinterface

// File: rtl/perip_bus_initiator.sv
// Turns one core request into a single-cycle peripheral bus write or read
// strobe and returns exactly one response. One transaction outstanding.
module perip_bus_initiator
  import perip_bus_initiator_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  perip_bus_initiator_if.master bus,
  output state_t                o_dbg_state
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  // A zero read latency would sample data the slave has not produced yet
  if (RD_LAT < 1) begin : g_bad_rd_lat
    $error("perip_bus_initiator: RD_LAT must be at least 1");
  end

  state_t            r_state;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_data;
  logic [SEL_W-1:0]  r_sel;
  logic              r_we;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_rd;
  logic [CNT_W-1:0]  r_cnt;

  logic w_accept;
  logic w_unaligned;

  assign w_accept    = bus.req_valid_i && r_req_ready;
  assign w_unaligned = is_unaligned(bus.req_addr_i[1:0]);

  // Transaction FSM; every output is a register written here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_waddr     <= '0;
      r_data      <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_raddr     <= '0;
      r_rd        <= 1'b0;
      r_cnt       <= '0;
    end else begin
      // strobes are single-cycle pulses unless re-asserted below
      r_we <= 1'b0;
      r_rd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            if (w_unaligned) begin
              // bad address: answer straight away, bus untouched
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else if (bus.req_we_i) begin
              r_state <= ST_WRITE;
              r_we    <= 1'b1;
              r_waddr <= bus.req_addr_i;
              r_data  <= bus.req_wdata_i;
              r_sel   <= bus.req_sel_i;
            end else begin
              r_state <= ST_READ_WAIT;
              r_rd    <= 1'b1;
              r_raddr <= bus.req_addr_i;
              r_cnt   <= CNT_W'(RD_LAT);
            end
          end
        end
        ST_WRITE: begin
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        ST_READ_WAIT: begin
          // counter reaches zero in the cycle the slave data is valid
          if (r_cnt == '0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= bus.data_i;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o = r_req_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.waddr_o     = r_waddr;
  assign bus.data_o      = r_data;
  assign bus.sel_o       = r_sel;
  assign bus.we_o        = r_we;
  assign bus.raddr_o     = r_raddr;
  assign bus.rd_o        = r_rd;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_perip_bus_initiator.sv
// Directed bench for perip_bus_initiator: one instance with RD_LAT=1 and one
// with RD_LAT=3 share the stimulus; use3 picks which one is driven/observed.
module tb_perip_bus_initiator;
  import perip_bus_initiator_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus variables ----------------
  logic        use3      = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [7:0]  req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_sel   = '0;
  logic        rsp_ready = 1'b0;

  perip_bus_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
  perip_bus_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();
  state_t dbg1, dbg3;

  perip_bus_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .o_dbg_state(dbg1));
  perip_bus_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .o_dbg_state(dbg3));

  assign bus1.req_valid_i = req_valid & ~use3;
  assign bus3.req_valid_i = req_valid & use3;
  assign bus1.req_we_i    = req_we;
  assign bus3.req_we_i    = req_we;
  assign bus1.req_addr_i  = req_addr;
  assign bus3.req_addr_i  = req_addr;
  assign bus1.req_wdata_i = req_wdata;
  assign bus3.req_wdata_i = req_wdata;
  assign bus1.req_sel_i   = req_sel;
  assign bus3.req_sel_i   = req_sel;
  assign bus1.rsp_ready_i = rsp_ready;
  assign bus3.rsp_ready_i = rsp_ready;

  // ---------------- observed outputs of the selected instance ----------------
  logic        w_req_ready, w_rsp_valid, w_err, w_we, w_rd;
  logic [31:0] w_rdata, w_data;
  logic [7:0]  w_waddr, w_raddr;
  logic [3:0]  w_sel;
  state_t      w_state;
  assign w_req_ready = use3 ? bus3.req_ready_o : bus1.req_ready_o;
  assign w_rsp_valid = use3 ? bus3.rsp_valid_o : bus1.rsp_valid_o;
  assign w_err       = use3 ? bus3.rsp_err_o   : bus1.rsp_err_o;
  assign w_rdata     = use3 ? bus3.rsp_rdata_o : bus1.rsp_rdata_o;
  assign w_we        = use3 ? bus3.we_o        : bus1.we_o;
  assign w_rd        = use3 ? bus3.rd_o        : bus1.rd_o;
  assign w_waddr     = use3 ? bus3.waddr_o     : bus1.waddr_o;
  assign w_data      = use3 ? bus3.data_o      : bus1.data_o;
  assign w_sel       = use3 ? bus3.sel_o       : bus1.sel_o;
  assign w_raddr     = use3 ? bus3.raddr_o     : bus1.raddr_o;
  assign w_state     = use3 ? dbg3 : dbg1;

  // ---------------- slave stub: register file with registered read data ----------------
  function automatic logic [31:0] init_val(input int i);
    return (i == 3) ? 32'h0000_1234 : (32'hA500_0000 | 32'(i));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  logic [31:0] regs [0:63];
  logic        pipe1;
  logic [2:0]  pipe3;

  always @(posedge clk) begin
    if (rst) begin
      pipe1 <= 1'b0;
      pipe3 <= '0;
      for (int i = 0; i < 64; i++) regs[i] <= init_val(i);
    end else begin
      pipe1 <= bus1.rd_o;
      pipe3 <= {pipe3[1:0], bus3.rd_o};
      if (w_we) regs[w_waddr[7:2]] <= merge(regs[w_waddr[7:2]], w_data, w_sel);
    end
  end

  // data is valid only RD_LAT cycles after the strobe; garbage otherwise
  assign bus1.data_i = pipe1    ? regs[bus1.raddr_o[7:2]] : 32'hDEAD_BEEF;
  assign bus3.data_i = pipe3[2] ? regs[bus3.raddr_o[7:2]] : 32'hDEAD_BEEF;

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model [0:63];
  logic        have_w = 1'b0;
  logic [7:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_init();
    for (int i = 0; i < 64; i++) model[i] = init_val(i);
  endtask

  // One full transaction: drive, check strobe cycle, latency, payload, stall, release
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, input int rd_lat, input int stall);
    logic        err;
    int          exp_lat;
    int          k;
    int          strobes;
    logic [32:0] exp_v;
    err       = (addr[1:0] != 2'b00);
    rsp_ready = (stall == 0);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_sel   = sel;
    chk("req_ready_idle", 32'(w_req_ready), 32'd1);
    if (err) begin
      exp_q.push_back({1'b1, 32'h0});
      exp_lat = 1;
    end else if (we) begin
      model[addr[7:2]] = merge(model[addr[7:2]], wdata, sel);
      exp_q.push_back({1'b0, 32'h0});
      exp_lat = 2;
      have_w = 1'b1;
      last_waddr = addr;
      last_wdata = wdata;
    end else begin
      exp_q.push_back({1'b0, model[addr[7:2]]});
      exp_lat = 2 + rd_lat;
    end
    tick();
    req_valid = 1'b0;
    // first cycle after acceptance
    chk("we_pulse", 32'(w_we), 32'(!err && we));
    chk("rd_pulse", 32'(w_rd), 32'(!err && !we));
    chk("we_rd_excl", 32'(w_we & w_rd), 32'd0);
    if (!err && we) begin
      chk("waddr", 32'(w_waddr), 32'(addr));
      chk("wdata", w_data, wdata);
      chk("wsel", 32'(w_sel), 32'(sel));
    end
    if (!err && !we) chk("raddr", 32'(w_raddr), 32'(addr));
    strobes = int'(w_we) + int'(w_rd);
    k = 1;
    while (!w_rsp_valid && k < 20) begin
      tick();
      k++;
      strobes += int'(w_we) + int'(w_rd);
    end
    chk("rsp_latency", 32'(k), 32'(exp_lat));
    chk("strobe_count", 32'(strobes), err ? 32'd0 : 32'd1);
    exp_v = exp_q.pop_front();
    chk("rsp_err", 32'(w_err), 32'(exp_v[32]));
    chk("rsp_rdata", w_rdata, exp_v[31:0]);
    // back-pressure: response must hold, no new acceptance, bus quiet
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_valid", 32'(w_rsp_valid), 32'd1);
      chk("stall_rdata", w_rdata, exp_v[31:0]);
      chk("stall_err", 32'(w_err), 32'(exp_v[32]));
      chk("stall_req_ready", 32'(w_req_ready), 32'd0);
      chk("stall_strobes", 32'(w_we | w_rd), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    if (stall != 0) rsp_ready = 1'b0;
    chk("rsp_released", 32'(w_rsp_valid), 32'd0);
    chk("req_ready_back", 32'(w_req_ready), 32'd1);
    chk("state_idle", 32'(w_state), 32'(ST_IDLE));
    if (have_w) begin
      chk("waddr_hold", 32'(w_waddr), 32'(last_waddr));
      chk("wdata_hold", w_data, last_wdata);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] a;
    model_init();
    rst = 1'b1;
    repeat (3) tick();
    // reset state of both instances
    for (int u = 0; u < 2; u++) begin
      use3 = (u == 1);
      #1;
      chk("rst_req_ready", 32'(w_req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(w_rsp_valid), 32'd0);
      chk("rst_strobes", 32'(w_we | w_rd), 32'd0);
      chk("rst_rdata", w_rdata, 32'd0);
      chk("rst_err", 32'(w_err), 32'd0);
      chk("rst_waddr", 32'(w_waddr), 32'd0);
      chk("rst_state", 32'(w_state), 32'(ST_IDLE));
    end
    use3 = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // RD_LAT = 1 instance
    do_req(1'b1, TIMER_CMPO, 32'h0010_0020, 4'hF, 1, 0);
    do_req(1'b0, TIMER_TCOF, 32'h0, 4'h0, 1, 0);
    do_req(1'b1, 8'h05, 32'hFFFF_FFFF, 4'hF, 1, 0);
    do_req(1'b0, 8'h05, 32'h0, 4'h0, 1, 0);
    do_req(1'b0, 8'h06, 32'h0, 4'h0, 1, 0);
    do_req(1'b0, TIMER_CMPO, 32'h0, 4'h0, 1, 5);
    do_req(1'b1, 8'h10, 32'h1122_3344, 4'h0, 1, 0);
    do_req(1'b0, 8'h10, 32'h0, 4'h0, 1, 0);
    do_req(1'b1, 8'h10, 32'hCAFE_F00D, 4'b0101, 1, 2);
    do_req(1'b0, 8'h10, 32'h0, 4'h0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                      : 8'($urandom_range(0, 63) << 2);
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1,
             $urandom_range(0, 2));
    end

    // RD_LAT = 3 instance: reset while a read is in flight
    use3 = 1'b1;
    rsp_ready = 1'b1;
    #1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = TIMER_CAPI;
    chk("r5_req_ready", 32'(w_req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("r5_rd_pulse", 32'(w_rd), 32'd1);
    tick();
    chk("r5_in_read_wait", 32'(w_state), 32'(ST_READ_WAIT));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r5_rd_after_rst", 32'(w_rd), 32'd0);
    chk("r5_valid_after_rst", 32'(w_rsp_valid), 32'd0);
    chk("r5_ready_after_rst", 32'(w_req_ready), 32'd1);
    chk("r5_state_after_rst", 32'(w_state), 32'(ST_IDLE));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("r5_no_rsp", 32'(w_rsp_valid), 32'd0);
    end
    model_init();
    have_w = 1'b0;

    // back-to-back W, R, W with response ready held high
    do_req(1'b1, TIMER_CTRL, 32'h8000_0001, 4'hF, 3, 0);
    do_req(1'b0, TIMER_CTRL, 32'h0, 4'h0, 3, 0);
    do_req(1'b1, TIMER_CAPI, 32'h5A5A_A5A5, 4'b1100, 3, 0);
    do_req(1'b0, TIMER_CAPI, 32'h0, 4'h0, 3, 1);
    do_req(1'b0, 8'h0B, 32'h0, 4'h0, 3, 0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
